// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus endpoints (master_port / slave_port).
package bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    RSEND = 3'd5
  } slave_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register (LSB leaves first, new bits enter at the MSB) with
// parallel load and a count of shifts since the last load/clear.
module serial_shift_reg #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             cnt_clr,
  output logic [W-1:0]     q,
  output logic [W-1:0]     q_next,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0] shifted_s;

  // Shift-right view of the register and next-value select.
  always_comb begin
    shifted_s = q;
    for (int i = 0; i < W - 1; i++) begin
      shifted_s[i] = q[i+1];
    end
    shifted_s[W-1] = shift_in;
    if (load) begin
      q_next = load_data;
    end else if (shift_en) begin
      q_next = shifted_s;
    end else begin
      q_next = q;
    end
  end

  // Data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= {W{1'b0}};
    end else begin
      q <= q_next;
    end
  end

  // Bit counter; a clear wins over a coincident shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr || load) begin
      cnt <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: deserialises request frames into local write/read
// strobes and serialises read data back to the master.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode,
  input  logic              wr_bus,
  input  logic              master_valid,
  output logic              slave_ready,
  output logic              rd_bus,
  output logic              slave_valid,
  input  logic              master_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              s_wr_en,
  output logic              s_rd_en,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_rd_valid
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int REQ_CW  = $clog2(FRAME_W + 1);
  localparam int RD_CW   = $clog2(DATA_W + 1);

  slave_state_t state_r, state_next_s;
  logic mode_r;
  logic [ADDR_W-1:0] s_addr_r;
  logic [DATA_W-1:0] s_wr_data_r;

  logic req_shift_s, req_clr_s, rd_load_s, rd_shift_s, rd_clr_s;
  logic addr_latch_s, data_latch_s, mode_latch_s;
  logic [FRAME_W-1:0] req_q_s, req_next_s;
  logic [REQ_CW-1:0]  req_cnt_s;
  logic [DATA_W-1:0]  rd_q_s, rd_next_s;
  logic [RD_CW-1:0]   rd_cnt_s;
  logic               unused_ok_s;

  // Request bits enter at the MSB, so after N transfers the frame's first N
  // bits occupy the top N positions of req_next_s.
  serial_shift_reg #(.W(FRAME_W), .CNT_W(REQ_CW)) u_req_sr (
    .clk       (clk),
    .rstn      (rstn),
    .load      (1'b0),
    .load_data ({FRAME_W{1'b0}}),
    .shift_en  (req_shift_s),
    .shift_in  (wr_bus),
    .cnt_clr   (req_clr_s),
    .q         (req_q_s),
    .q_next    (req_next_s),
    .cnt       (req_cnt_s)
  );

  serial_shift_reg #(.W(DATA_W), .CNT_W(RD_CW)) u_rd_sr (
    .clk       (clk),
    .rstn      (rstn),
    .load      (rd_load_s),
    .load_data (s_rd_data),
    .shift_en  (rd_shift_s),
    .shift_in  (1'b0),
    .cnt_clr   (rd_clr_s),
    .q         (rd_q_s),
    .q_next    (rd_next_s),
    .cnt       (rd_cnt_s)
  );

  assign unused_ok_s = ^{req_q_s, rd_q_s, rd_next_s};

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    req_shift_s  = 1'b0;
    req_clr_s    = 1'b0;
    rd_load_s    = 1'b0;
    rd_shift_s   = 1'b0;
    rd_clr_s     = 1'b0;
    addr_latch_s = 1'b0;
    data_latch_s = 1'b0;
    mode_latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (master_valid) begin
          req_shift_s  = 1'b1;
          mode_latch_s = 1'b1;
          if (ADDR_W == 1) begin
            addr_latch_s = 1'b1;
            req_clr_s    = 1'b1;
            state_next_s = (mode == MODE_WRITE) ? WDATA : READ;
          end else begin
            state_next_s = ADDR;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        if (master_valid) begin
          req_shift_s = 1'b1;
          if (req_cnt_s == REQ_CW'(ADDR_W - 1)) begin
            addr_latch_s = 1'b1;
            req_clr_s    = 1'b1;
            state_next_s = (mode_r == MODE_READ) ? READ : WDATA;
          end else begin
            state_next_s = ADDR;
          end
        end else begin
          state_next_s = ADDR;
        end
      end
      WDATA: begin
        if (master_valid) begin
          req_shift_s = 1'b1;
          if (req_cnt_s == REQ_CW'(DATA_W - 1)) begin
            data_latch_s = 1'b1;
            req_clr_s    = 1'b1;
            state_next_s = WRITE;
          end else begin
            state_next_s = WDATA;
          end
        end else begin
          state_next_s = WDATA;
        end
      end
      WRITE: begin
        state_next_s = IDLE;
      end
      READ: begin
        if (s_rd_valid) begin
          rd_load_s    = 1'b1;
          state_next_s = RSEND;
        end else begin
          state_next_s = READ;
        end
      end
      RSEND: begin
        if (master_ready) begin
          rd_shift_s = 1'b1;
          if (rd_cnt_s == RD_CW'(DATA_W - 1)) begin
            rd_clr_s     = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = RSEND;
          end
        end else begin
          state_next_s = RSEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, latched mode and local address/data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      mode_r      <= MODE_READ;
      s_addr_r    <= {ADDR_W{1'b0}};
      s_wr_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (mode_latch_s) begin
        mode_r <= mode;
      end
      if (addr_latch_s) begin
        s_addr_r <= req_next_s[FRAME_W-1 -: ADDR_W];
      end
      if (data_latch_s) begin
        s_wr_data_r <= req_next_s[FRAME_W-1 -: DATA_W];
      end
    end
  end

  assign slave_ready = (state_r == IDLE) || (state_r == ADDR) || (state_r == WDATA);
  assign s_wr_en     = (state_r == WRITE);
  assign s_rd_en     = (state_r == READ);
  assign slave_valid = (state_r == RSEND);
  assign rd_bus      = rd_q_s[0];
  assign s_addr      = s_addr_r;
  assign s_wr_data   = s_wr_data_r;

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: a driver pushes expected transactions, a
// monitor pops and compares them whenever the DUT strobes or returns data.
module tb_slave_port;
  import bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn, mode, wr_bus, master_valid;
  logic          slave_ready, rd_bus, slave_valid;
  logic          master_ready = 1'b1;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wr_data;
  logic          s_wr_en, s_rd_en;
  logic [DW-1:0] s_rd_data = 8'h00;
  logic          s_rd_valid = 1'b0;

  exp_t wq[$];
  exp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] rd_byte = 8'h00;
  int rd_lat = 1;
  bit mr_toggle = 1'b0;
  bit junk_valid = 1'b0;

  slave_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid), .master_ready(master_ready),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_wr_en(s_wr_en),
    .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wr_data", s_wr_data, 0);
    chk("rst_rd_bus", rd_bus, 0);
    chk("rst_s_wr_en", s_wr_en, 0);
    chk("rst_s_rd_en", s_rd_en, 0);
    chk("rst_slave_valid", slave_valid, 0);
    chk("rst_slave_ready", slave_ready, 1);
  endtask

  // One request bit: driven after a falling edge where slave_ready is high.
  task automatic xfer(input logic b, input logic m);
    int g = 0;
    @(negedge clk);
    while (!slave_ready && g < 100) begin
      master_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("ready_timeout", 0, 1);
    master_valid = 1'b1;
    wr_bus = b;
    mode = m;
  endtask

  task automatic send_frame(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit flip, input int stall_at);
    exp_t e;
    e.addr = a;
    e.data = d;
    if (m == MODE_WRITE) wq.push_back(e);
    else begin
      rd_byte = d;
      rq.push_back(e);
    end
    for (int i = 0; i < AW; i++) begin
      xfer(a[i], (i == 0) ? m : (flip ? ~m : m));
      if (i == stall_at) repeat (3) begin
        @(negedge clk);
        master_valid = 1'b0;
      end
    end
    if (m == MODE_WRITE) for (int i = 0; i < DW; i++) xfer(d[i], flip ? ~m : m);
    @(negedge clk);
    master_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((wq.size() != 0 || rq.size() != 0 || slave_valid || !slave_ready) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("idle_reached", (g < 400), 1);
    @(negedge clk);
  endtask

  // Local storage model: answers s_rd_en after rd_lat cycles.
  initial begin
    int rd_wait = 0;
    forever begin
      @(negedge clk);
      if (s_rd_en) begin
        if (rd_wait >= rd_lat) begin
          s_rd_valid = 1'b1;
          s_rd_data = rd_byte;
        end else begin
          s_rd_valid = 1'b0;
          rd_wait++;
        end
      end else begin
        rd_wait = 0;
        s_rd_valid = junk_valid;
        s_rd_data = 8'hEE;
      end
    end
  end

  // Monitor: drives master_ready, collects rd_bus bits, checks strobes.
  initial begin
    exp_t e;
    int nbits = 0;
    int rd_en_cyc = 0;
    logic [DW-1:0] acc = 8'h00;
    bit prev_wr = 1'b0, prev_sv = 1'b0, prev_mr = 1'b1, prev_rd = 1'b0, prev_done = 1'b0;
    forever begin
      @(negedge clk);
      master_ready = mr_toggle ? ~master_ready : 1'b1;
      if (!rstn) begin
        nbits = 0; rd_en_cyc = 0;
        prev_wr = 1'b0; prev_sv = 1'b0; prev_done = 1'b0;
      end else begin
        if (prev_wr) begin
          chk("wr_en_single", s_wr_en, 0);
          chk("ready_after_write", slave_ready, 1);
        end
        if (prev_done) chk("valid_after_byte", slave_valid, 0);
        prev_done = 1'b0;
        if (s_wr_en) begin
          chk("ready_in_write", slave_ready, 0);
          if (wq.size() == 0) chk("stray_wr_en", 1, 0);
          else begin
            e = wq.pop_front();
            chk("s_addr", s_addr, e.addr);
            chk("s_wr_data", s_wr_data, e.data);
          end
        end
        if (s_rd_en) begin
          rd_en_cyc++;
          if (rq.size() == 0) chk("stray_rd_en", 1, 0);
          else chk("rd_addr", s_addr, rq[0].addr);
        end
        if (slave_valid && !prev_sv) begin
          chk("rd_en_cycles", rd_en_cyc, rd_lat + 1);
          rd_en_cyc = 0;
        end
        if (prev_sv && slave_valid && !prev_mr) chk("rd_bus_hold", rd_bus, prev_rd);
        if (slave_valid && master_ready) begin
          acc[nbits] = rd_bus;
          nbits++;
          if (nbits == DW) begin
            nbits = 0;
            prev_done = 1'b1;
            if (rq.size() == 0) chk("stray_rd_byte", 1, 0);
            else begin
              e = rq.pop_front();
              chk("rd_byte", acc, e.data);
            end
          end
        end
        prev_wr = s_wr_en;
        prev_sv = slave_valid;
        prev_rd = rd_bus;
      end
      prev_mr = master_ready;
    end
  end

  // Directed stimulus.
  initial begin
    int g;
    rstn = 1'b0; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rstn = 1'b1;
    @(negedge clk);

    send_frame(MODE_WRITE, 12'h3CD, 8'hD3, 1'b0, -1);
    wait_idle();
    rd_lat = 1;
    send_frame(MODE_READ, 12'h0AB, 8'h5A, 1'b0, -1);
    wait_idle();

    send_frame(MODE_WRITE, 12'h3CD, 8'hD3, 1'b0, 5);
    wait_idle();
    mr_toggle = 1'b1;
    send_frame(MODE_READ, 12'h0AB, 8'h5A, 1'b0, 5);
    wait_idle();
    mr_toggle = 1'b0;

    send_frame(MODE_WRITE, 12'h155, 8'hA7, 1'b1, -1);
    wait_idle();
    send_frame(MODE_READ, 12'h2F0, 8'h3C, 1'b1, -1);
    wait_idle();

    junk_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("junk_slave_valid", slave_valid, 0);
    chk("junk_slave_ready", slave_ready, 1);
    junk_valid = 1'b0;
    @(negedge clk);

    send_frame(MODE_READ, 12'h123, 8'hC3, 1'b0, -1);
    g = 0;
    while (!slave_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rsend_reached", slave_valid, 1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset();
    rq.delete();
    @(negedge clk);
    #2 rstn = 1'b1;
    send_frame(MODE_WRITE, 12'h001, 8'hFF, 1'b0, -1);
    wait_idle();

    rd_lat = 0;
    send_frame(MODE_WRITE, 12'h2A5, 8'h5C, 1'b0, -1);
    send_frame(MODE_READ, 12'h4E1, 8'h96, 1'b0, -1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Bus-side endpoint that sits directly downstream of `master_port` on the serial system bus. It deserialises the request frame that the master shifts out on `wr_bus`, turning it into a slave-local address and write data. It then issues a single write or read strobe to the local storage. For reads, it serialises the returned byte back to the master on `rd_bus` under a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, default 12: slave-local address width, in bits, carried in each frame.
- `DATA_W`, default 8: data width, in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset; one clock, reset asynchronous and active-low.
- `mode`  in  1  request type from the master: 1 = write, 0 = read.
- `wr_bus`  in  1  serial request bits from the master, LSB first.
- `master_valid`  in  1  `wr_bus` carries a valid bit this cycle.
- `slave_ready`  out  1  slave accepts request bits.
- `rd_bus`  out  1  serial read data to the master, LSB first.
- `slave_valid`  out  1  `rd_bus` carries a valid bit.
- `master_ready`  in  1  master consumes the `rd_bus` bit this cycle.
- `s_addr`  out  ADDR_W  local address.
- `s_wr_data`  out  DATA_W  local write data.
- `s_wr_en`  out  1  local write strobe.
- `s_rd_en`  out  1  local read request.
- `s_rd_data`  in  DATA_W  local read data.
- `s_rd_valid`  in  1  `s_rd_data` is valid.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, READ, RSEND. The reset state is IDLE.
- Bit transfer: a request bit transfers only on an edge where `master_valid` and `slave_ready` are both 1.
- `slave_ready` decode: 1 in IDLE, ADDR and WDATA; 0 in all other states.
- IDLE:
  - On a transfer: latch `mode`, load `wr_bus` as address bit 0, set the bit counter to 1, go to ADDR.
  - If ADDR_W = 1, go directly to the state that follows ADDR.
- ADDR:
  - Each transfer shifts the next address bit in.
  - After bit ADDR_W-1: go to WDATA if the latched mode = 1, else go to READ. Clear the counter.
- WDATA:
  - Each transfer shifts the next data bit in.
  - After bit DATA_W-1, go to WRITE.
- WRITE: `s_wr_en` = 1 for exactly one cycle, then go to IDLE.
- READ:
  - `s_rd_en` = 1 until `s_rd_valid` = 1; `s_rd_valid` may already be high in the first READ cycle.
  - On that edge, load `s_rd_data` into the output shift register and go to RSEND.
- RSEND:
  - `slave_valid` = 1; `rd_bus` = shift register bit 0.
  - Each edge with `master_ready` = 1 shifts right and increments the counter.
  - After DATA_W accepted bits, go to IDLE.
- `s_addr` and `s_wr_data` are registers. They hold their values until the next frame overwrites them.
- Boundary rules:
  - `master_valid` low mid-frame: stall with all state held. There is no timeout.
  - `mode` is sampled only on the first bit; later changes are ignored.
  - `s_rd_valid` outside READ is ignored.
  - `master_ready` low in RSEND: `rd_bus` is held unchanged.
  - `rstn` asserted in any state: immediately return to IDLE and clear all registers. A partial frame is discarded with no strobe.

## Timing
- Reset values:
  - `s_addr` = 0, `s_wr_data` = 0, `rd_bus` = 0.
  - `s_wr_en` = 0, `s_rd_en` = 0, `slave_valid` = 0.
  - `slave_ready` = 1, since it is decoded from IDLE.
- Write frame: ADDR_W + DATA_W transfer cycles. `s_wr_en` is high in the cycle after the last data bit is sampled, with `s_addr`/`s_wr_data` already stable.
- Read frame:
  - `s_rd_en` is high in the cycle after the last address bit is sampled.
  - `slave_valid` rises the cycle after the `s_rd_valid` edge.
  - DATA_W handshaked bits follow.
- Back-to-back frames: IDLE accepts a new first bit in the cycle after WRITE, or after the last RSEND transfer.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Shared package `bus_pkg`:
  - state enum `slave_state_t`;
  - default `ADDR_W`/`DATA_W` constants;
  - `MODE_WRITE`/`MODE_READ` constants.
  
  `master_port` imports the same package.
- One natural sub-module: `serial_shift_reg`, a parameterised shift register with load, shift-in and shift-out, plus a bit counter. It is instantiated twice: once for request deserialisation, once for read serialisation.

## Test plan
- Write: addr 0x3CD, data 0xD3, `mode` = 1, `master_valid` continuous → exactly one `s_wr_en` pulse with `s_addr` = 0x3CD and `s_wr_data` = 0xD3; `slave_ready` low for that cycle only.
- Read: addr 0x0AB, local returns 0x5A one cycle after `s_rd_en`, `master_ready` = 1 → `rd_bus` sequence 0,1,0,1,1,0,1,0 with `slave_valid` high for exactly 8 cycles.
- Stalls: `master_valid` low for 3 cycles after address bit 5, and `master_ready` toggling 1,0,1,0 during RSEND → same results as the unstalled runs; `rd_bus` holds during stalls.
- `mode` flipped after the first bit → the frame follows the latched mode.
- Reset pulse in mid-RSEND, then a fresh write of 0x001/0xFF → outputs return to reset values immediately; the new write completes correctly with no stray strobes.
- Back-to-back write then read with no idle gap → both complete with correct strobes and data.
